sha256_core: RTL and testbench

- Iterative SHA-256 compression engine (FIPS 180-4) processing one pre-padded 512-bit block per start, one round per clock.
- Instantiated by the top-level benchmark wrapper.
- Clocked from the ice40up5k internal high-frequency oscillator on hardware, or from the bench clock in simulation.
- Padding and message framing are done outside the core.

---
 rtl/sha256_core.sv | 94 +++++++++
 tb/tb_sha256_core.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sha256_core.sv
// sha256_core: iterative SHA-256 compression, one round per clock, 66 cycles per block.
// Define SHA224_EN to add the mode224 port selecting the SHA-224 IV and truncated digest.
module sha256_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
`ifdef SHA224_EN
  input  logic         mode224,
`endif
  input  logic [511:0] block,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] ep0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] ep1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] sg0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sg1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  state_t state, nxt;
  logic [0:7][31:0]  hs, v, hn;
  logic [0:15][31:0] w;
  logic [5:0]        t;
  logic [31:0]       t1, t2, wn;
  logic [255:0]      iv, dig;
`ifdef SHA224_EN
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  logic m224;
  assign iv = mode224 ? IV224 : IV256;
  assign digest = {dig[255:32], m224 ? 32'h0 : dig[31:0]};
  always_ff @(posedge clk)
    m224 <= rst ? 1'b0 : (state == IDLE && start && init) ? mode224 : m224;
`else
  assign iv = IV256;
  assign digest = dig;
`endif
  assign ready = state == IDLE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (start ? ROUND : IDLE) :
          state == ROUND ? (t == 6'd63 ? FINAL : ROUND) : IDLE;
  always_comb begin
    t1 = v[7] + ep1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[0];
    t2 = ep0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    // window head is W[t]; the word appended is W[t+16]
    wn = sg1(w[14]) + w[9] + sg0(w[1]) + w[0];
    for (int i = 0; i < 8; i++) hn[i] = hs[i] + v[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hs   <= IV256;
      dig  <= IV256;
      v    <= IV256;
      w    <= '0;
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FINAL;
      if (state == IDLE && start) begin
        w <= block;
        t <= '0;
        if (init) hs <= iv;
        v <= init ? iv : hs;
      end else if (state == ROUND) begin
        v <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
        w <= {w[1:15], wn};
        t <= t + 6'd1;
      end else if (state == FINAL) begin
        hs  <= hn;
        dig <= hn;
      end
    end
  end
endmodule

// File: tb/tb_sha256_core.sv
// tb_sha256_core: scoreboard bench for sha256_core; known-answer digests and done latency.
module tb_sha256_core;
  localparam logic [255:0] IV256  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY  = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                                 32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                                 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
  localparam logic [511:0] B2   = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  logic clk = 0, rst = 1, start = 0, init = 0, mode224 = 0;
  logic [511:0] block = '0;
  logic ready, done;
  logic [255:0] digest;
  int cyc = 0, total = 0, bad = 0;
  logic [255:0] exp_q[$];
  bit vld_q[$];
  int cyc_q[$];
  sha256_core dut (
    .clk(clk), .rst(rst), .start(start), .init(init),
`ifdef SHA224_EN
    .mode224(mode224),
`endif
    .block(block), .ready(ready), .done(done), .digest(digest));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("spurious_done", 256'(done), 256'(0));
      else begin
        logic [255:0] e;
        bit vl;
        int c;
        e = exp_q.pop_front();
        vl = vld_q.pop_front();
        c = cyc_q.pop_front();
        if (vl) chk("digest", digest, e);
        chk("latency", 256'(cyc), 256'(c));
      end
    end
  task automatic go(input logic [511:0] b, input logic i, input logic [255:0] e, input bit vl, input bit b2b);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 256'(ready), 256'(1));
    if (b2b) chk("b2b_done", 256'(done), 256'(1));
    start = 1;
    block = b;
    init = i;
    exp_q.push_back(e);
    vld_q.push_back(vl);
    cyc_q.push_back(cyc + 66);
    @(negedge clk);
    start = 0;
    block = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    init = 1'($urandom);
    chk("ready_low", 256'(ready), 256'(0));
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 256'(exp_q.size()), 256'(0));
  endtask
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready", 256'(ready), 256'(1));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_digest", digest, IV256);
    go(ABC, 1, ABC_D, 1, 0);
    drain();
    chk("hold_digest", digest, ABC_D);
    go(EMPTY, 1, EMPTY_D, 1, 0);
    drain();
    go(B1, 1, '0, 0, 0);
    repeat (20) @(negedge clk);
    start = 1;
    init = 1;
    block = ABC;
    @(negedge clk);
    start = 0;
    go(B2, 0, TWO_D, 1, 1);
    drain();
    go(ABC, 1, ABC_D, 0, 0);
    repeat (30) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    vld_q.delete();
    cyc_q.delete();
    chk("abort_ready", 256'(ready), 256'(1));
    chk("abort_done", 256'(done), 256'(0));
    chk("abort_digest", digest, IV256);
    repeat (80) @(negedge clk);
    chk("abort_hold", digest, IV256);
    go(ABC, 1, ABC_D, 1, 0);
    drain();
`ifdef SHA224_EN
    mode224 = 1;
    go(ABC, 1, {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 1, 0);
    drain();
    mode224 = 0;
    go(ABC, 1, ABC_D, 1, 0);
    drain();
`endif
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
